bus_datapath: RTL and testbench
===============================

// Module: bus_datapath
// PURPOSE
//  Single-bus datapath driven cycle-by-cycle by the multicycle controller FSM.
//  Holds IR, MDR, MAR, SP, PC and T, a shared internal bus, the ALU, and the Z/N/C flags.
//  Returns ir[6:0] and dcond to the controller and drives the memory and register-file strobes.
// PARAMETERS
//  DW       8     data/address width (>= 8)
//  SP_INIT  8'hFF SP value after reset
//  PC_INIT  8'h00 PC value after reset
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-high reset
//  ldir,ldmdr,ldmar,ldsp,ldpc,ldt  in 1 each  register load enables (from controller)
//  tir,tmdr,tsp,tpc,tt  in  1 each  internal-bus drive enables
//  tmar       in   1   MAR drives mem_addr; when 0, mem_addr = 0
//  rd         in   1   register file drives the bus with rf_rdata
//  wr         in   1   register-file write strobe
//  memrd      in   1   memory read; loads selected from mem_rdata
//  memwr      in   1   memory write strobe
//  fnsel      in   3   ALU op: 000 add, 001 neg, 010 inc, 011 dec, 100 or, 101 not, 110 trans, 111 rsvd
//  M1         in   1   1: ALU op = fnsel; 0: ALU op = trans
//  ir         out  7   IR[6:0] to controller (opcode = ir[6:3], sub = ir[2:0])
//  dcond      out  1   branch condition met (combinational)
//  mem_addr   out  DW  memory address
//  mem_wdata  out  DW  = MDR
//  mem_we     out  1   = memwr
//  mem_rdata  in   DW  memory read data (combinational, same cycle)
//  rf_rdata   in   DW  register-file read data
//  rf_wdata   out  DW  = ALU result y
//  rf_we      out  1   = wr
//  bus_err    out  1   sticky: more than one bus driver seen
// BEHAVIOUR
//  Reset (clk edge with reset=1):
//   - IR, MDR, MAR, T = 0; PC = PC_INIT; SP = SP_INIT; Z, N, C, bus_err = 0.
//   - Reset overrides every load in the same cycle.
//  Bus:
//   - Drivers: tir (sign-extended IR[2:0]), tmdr, tsp, tpc, tt, rd (rf_rdata).
//   - Priority if several are asserted: tir > tmdr > tsp > tpc > tt > rd.
//   - No driver asserted -> bus = 0.
//   - Two or more drivers -> bus_err set next edge; bus_err holds until reset.
//  ALU: y = f(bus, T), DW bits, carry-out c.
//   - add: bus+T
//   - neg: ~bus+1
//   - inc: bus+1
//   - dec: bus-1, c = no-borrow
//   - or: bus|T
//   - not: ~bus
//   - trans/rsvd: y = bus, c = 0
//   - All results wrap mod 2^DW.
//  Loads (edge, after reset check):
//   - ldmar/ldsp/ldpc/ldt load y.
//   - ldir loads mem_rdata if memrd=1, else y.
//   - ldmdr loads mem_rdata if memrd=1, else y.
//   - Several ld* in one cycle all load the same y; each register reads its old value via
//     the bus (e.g. tpc+ldpc+inc gives PC <= PC+1 in one cycle).
//  Flags: update only when M1=1 and fnsel in {000..101}.
//   - Z = (y==0); N = y[DW-1]; C = c.
//   - Otherwise flags hold.
//  dcond, decoded from ir[6:3]:
//   - 0000 -> 1; 0001 -> Z; 0010 -> !Z; 0011 -> N; 0100 -> !N; 0101 -> C; 0110 -> !C
//   - all other codes -> 0
//  Memory latency: zero wait states. memrd and memwr in the same cycle: both act, with
//   write data = current MDR.
// TESTING
//  1. Reset, then tpc+ldmar+M1+trans -> MAR=00; then tmar+tpc+ldpc+ldir+memrd+inc with
//     mem_rdata=8'hF8 -> IR=F8, PC=01, ir=7'h78.
//  2. SP=FF, tsp+ldsp+M1+dec -> SP=FE, Z=0, N=1, C=1; repeat from SP=00 -> SP=FF, C=0.
//  3. IR=8'h0D, PC=10: tir+ldt+M1=0 -> T=FD (sign-extended 101); tpc+tt+ldpc+add is
//     asserted -> bus_err=1. Then reset, and tpc+ldpc+M1+add with T preset to FD ->
//     PC=0D with no bus_err.
//  4. Z=1, ir[6:3]=0001 -> dcond=1; 0010 -> 0; 1111 -> 0.
//  5. MDR=5A, memwr=1 -> mem_we=1, mem_wdata=5A; rd+rf_rdata=33+ldmdr -> MDR=33.
//  6. Reset asserted with ldpc=1 and inc active -> PC=PC_INIT, flags cleared.

Source files
------------

// File: rtl/bus_datapath.sv
// Single-bus datapath for the multicycle controller: IR/MDR/MAR/SP/PC/T, shared bus,
// ALU and Z/N/C flags, stepped one micro-operation per clock.
module bus_datapath #(
  parameter int             DW      = 8,
  parameter logic [DW-1:0]  SP_INIT = 8'hFF,
  parameter logic [DW-1:0]  PC_INIT = 8'h00
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ldir,
  input  logic          ldmdr,
  input  logic          ldmar,
  input  logic          ldsp,
  input  logic          ldpc,
  input  logic          ldt,
  input  logic          tir,
  input  logic          tmdr,
  input  logic          tsp,
  input  logic          tpc,
  input  logic          tt,
  input  logic          tmar,
  input  logic          rd,
  input  logic          wr,
  input  logic          memrd,
  input  logic          memwr,
  input  logic [2:0]    fnsel,
  input  logic          M1,
  output logic [6:0]    ir,
  output logic          dcond,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  input  logic [DW-1:0] rf_rdata,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_we,
  output logic          bus_err
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_NEG   = 3'b001;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_NOT   = 3'b101;
  localparam logic [2:0] OP_TRANS = 3'b110;

  // Only IR[6:0] is ever consumed (opcode, sub-field and the bus sign-extension).
  logic [6:0]    ir_q;
  logic [DW-1:0] mdr_q;
  logic [DW-1:0] mar_q;
  logic [DW-1:0] sp_q;
  logic [DW-1:0] pc_q;
  logic [DW-1:0] t_q;
  logic          z_q;
  logic          n_q;
  logic          c_q;
  logic          bus_err_q;

  logic signed [DW-1:0] ir_sext;
  logic [DW-1:0]        bus;
  logic                 multi_drv;
  logic [2:0]           alu_op;
  logic [DW:0]          alu_res;
  logic [DW-1:0]        y;
  logic                 cout;
  logic                 flag_en;

  // ALU: returns {carry, result}; every result wraps modulo 2^DW.
  function automatic logic [DW:0] alu(input logic [2:0] op,
                                      input logic [DW-1:0] a,
                                      input logic [DW-1:0] b);
    logic [DW:0] r;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_NEG:  r = {1'b0, ~a} + (DW+1)'(1);
      OP_INC:  r = {1'b0, a} + (DW+1)'(1);
      OP_DEC:  r = {(a != '0), a - DW'(1)};
      OP_OR:   r = {1'b0, a | b};
      OP_NOT:  r = {1'b0, ~a};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  function automatic logic cond_met(input logic [3:0] code,
                                    input logic z, input logic n, input logic c);
    logic m;
    case (code)
      4'b0000: m = 1'b1;
      4'b0001: m = z;
      4'b0010: m = ~z;
      4'b0011: m = n;
      4'b0100: m = ~n;
      4'b0101: m = c;
      4'b0110: m = ~c;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  assign ir_sext = DW'(signed'(ir_q[2:0]));

  // Fixed-priority bus source select; an idle bus reads as zero.
  always_comb begin
    bus = '0;
    if (tir)       bus = ir_sext;
    else if (tmdr) bus = mdr_q;
    else if (tsp)  bus = sp_q;
    else if (tpc)  bus = pc_q;
    else if (tt)   bus = t_q;
    else if (rd)   bus = rf_rdata;
  end

  assign multi_drv = ($countones({tir, tmdr, tsp, tpc, tt, rd}) > 1);

  assign alu_op  = M1 ? fnsel : OP_TRANS;
  assign alu_res = alu(alu_op, bus, t_q);
  assign y       = alu_res[DW-1:0];
  assign cout    = alu_res[DW];
  assign flag_en = M1 && (fnsel <= OP_NOT);

  // Register stage: every load sees the same y, computed from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q      <= '0;
      mdr_q     <= '0;
      mar_q     <= '0;
      t_q       <= '0;
      pc_q      <= PC_INIT;
      sp_q      <= SP_INIT;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      c_q       <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (ldir)  ir_q  <= memrd ? mem_rdata[6:0] : y[6:0];
      if (ldmdr) mdr_q <= memrd ? mem_rdata : y;
      if (ldmar) mar_q <= y;
      if (ldsp)  sp_q  <= y;
      if (ldpc)  pc_q  <= y;
      if (ldt)   t_q   <= y;
      if (flag_en) begin
        z_q <= (y == '0);
        n_q <= y[DW-1];
        c_q <= cout;
      end
      if (multi_drv) bus_err_q <= 1'b1;
    end
  end

  assign ir        = ir_q;
  assign dcond     = cond_met(ir_q[6:3], z_q, n_q, c_q);
  assign mem_addr  = tmar ? mar_q : '0;
  assign mem_wdata = mdr_q;
  assign mem_we    = memwr;
  assign rf_wdata  = y;
  assign rf_we     = wr;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_bus_datapath.sv
// Bench for bus_datapath: constant-expectation vector table, hand sequences for the
// multi-cycle corners, and a randomized run against a behavioural reference model.
module tb_bus_datapath;

  localparam int LDIR  = 1 << 0;
  localparam int LDMDR = 1 << 1;
  localparam int LDMAR = 1 << 2;
  localparam int LDSP  = 1 << 3;
  localparam int LDPC  = 1 << 4;
  localparam int LDT   = 1 << 5;
  localparam int TIR   = 1 << 6;
  localparam int TMDR  = 1 << 7;
  localparam int TSP   = 1 << 8;
  localparam int TPC   = 1 << 9;
  localparam int TT    = 1 << 10;
  localparam int TMAR  = 1 << 11;
  localparam int RD    = 1 << 12;
  localparam int WR    = 1 << 13;
  localparam int MEMRD = 1 << 14;
  localparam int MEMWR = 1 << 15;

  localparam int OBS_MAR  = -1;
  localparam int OBS_MDR  = -2;
  localparam int OBS_IR   = -3;
  localparam int OBS_BERR = -4;

  logic       clk = 1'b0;
  logic       reset;
  logic       ldir, ldmdr, ldmar, ldsp, ldpc, ldt;
  logic       tir, tmdr, tsp, tpc, tt, tmar, rd, wr, memrd, memwr;
  logic [2:0] fnsel;
  logic       M1;
  logic [6:0] ir;
  logic       dcond;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, rf_rdata, rf_wdata;
  logic       mem_we, rf_we, bus_err;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bus_datapath #(.DW(8), .SP_INIT(8'hFF), .PC_INIT(8'h00)) dut (
    .clk(clk), .reset(reset),
    .ldir(ldir), .ldmdr(ldmdr), .ldmar(ldmar), .ldsp(ldsp), .ldpc(ldpc), .ldt(ldt),
    .tir(tir), .tmdr(tmdr), .tsp(tsp), .tpc(tpc), .tt(tt), .tmar(tmar),
    .rd(rd), .wr(wr), .memrd(memrd), .memwr(memwr), .fnsel(fnsel), .M1(M1),
    .ir(ir), .dcond(dcond), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .rf_rdata(rf_rdata),
    .rf_wdata(rf_wdata), .rf_we(rf_we), .bus_err(bus_err)
  );

  typedef struct {
    string      name;
    int         ctl;
    logic [2:0] fn;
    logic       m1;
    logic [7:0] mrd;
    logic [7:0] rfd;
    int         obs;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input int c, input logic [2:0] f, input logic m,
                       input logic [7:0] mr, input logic [7:0] rr);
    ldir = c[0];   ldmdr = c[1];  ldmar = c[2];  ldsp = c[3];
    ldpc = c[4];   ldt = c[5];    tir = c[6];    tmdr = c[7];
    tsp = c[8];    tpc = c[9];    tt = c[10];    tmar = c[11];
    rd = c[12];    wr = c[13];    memrd = c[14]; memwr = c[15];
    fnsel = f; M1 = m; mem_rdata = mr; rf_rdata = rr;
  endtask

  task automatic idle();
    drive(0, 3'b110, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic step(input int c, input logic [2:0] f, input logic m,
                      input logic [7:0] mr, input logic [7:0] rr);
    drive(c, f, m, mr, rr);
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Read a register through the ports without clocking (bus pass-through on rf_wdata).
  task automatic peek(input int obs, output logic [7:0] v);
    case (obs)
      OBS_MAR:  begin tmar = 1'b1; #1; v = mem_addr; end
      OBS_MDR:  begin #1; v = mem_wdata; end
      OBS_IR:   begin #1; v = {1'b0, ir}; end
      OBS_BERR: begin #1; v = {7'b0, bus_err}; end
      default:  begin drive(obs, 3'b110, 1'b0, 8'h00, 8'h00); #1; v = rf_wdata; end
    endcase
    idle();
    #1;
  endtask

  task automatic peek_check(input string name, input int obs, input logic [7:0] exp);
    logic [7:0] v;
    peek(obs, v);
    check(name, v, exp);
  endtask

  function automatic logic spec_cond(input logic [3:0] code, input logic z,
                                     input logic n, input logic c);
    case (code)
      4'd0: return 1'b1;
      4'd1: return z;
      4'd2: return !z;
      4'd3: return n;
      4'd4: return !n;
      4'd5: return c;
      4'd6: return !c;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_code(input logic [3:0] code);
    step(MEMRD | LDIR, 3'b110, 1'b0, {1'b0, code, 3'b000}, 8'h00);
  endtask

  task automatic check_flags(input string name, input logic z, input logic n, input logic c);
    set_code(4'd1); #1; check({name, "_z"}, dcond, z);
    set_code(4'd3); #1; check({name, "_n"}, dcond, n);
    set_code(4'd5); #1; check({name, "_c"}, dcond, c);
  endtask

  // Reference model state.
  logic [7:0] m_ir, m_mdr, m_mar, m_sp, m_pc, m_t;
  logic       m_z, m_n, m_c, m_berr;

  task automatic model_reset();
    m_ir = 0; m_mdr = 0; m_mar = 0; m_t = 0; m_pc = 8'h00; m_sp = 8'hFF;
    m_z = 0; m_n = 0; m_c = 0; m_berr = 0;
  endtask

  task automatic model_eval(output logic [7:0] y, output logic c, output int ndrv);
    logic [7:0] src[6];
    logic       en[6];
    logic [7:0] b;
    int         a, r, op;
    src[0] = {{5{m_ir[2]}}, m_ir[2:0]}; en[0] = tir;
    src[1] = m_mdr;                     en[1] = tmdr;
    src[2] = m_sp;                      en[2] = tsp;
    src[3] = m_pc;                      en[3] = tpc;
    src[4] = m_t;                       en[4] = tt;
    src[5] = rf_rdata;                  en[5] = rd;
    b = 0; ndrv = 0;
    for (int i = 5; i >= 0; i--) if (en[i]) begin b = src[i]; ndrv++; end
    a = int'(b);
    op = M1 ? int'(fnsel) : 6;
    c = 0;
    case (op)
      0: begin r = a + int'(m_t); y = 8'(r); c = (r > 255); end
      1: begin r = (255 - a) + 1; y = 8'(r); c = (r > 255); end
      2: begin r = a + 1;         y = 8'(r); c = (r > 255); end
      3: begin y = 8'((a + 255) % 256); c = (a > 0); end
      4: y = b | m_t;
      5: y = 8'(255 - a);
      default: y = b;
    endcase
  endtask

  task automatic model_update(input logic [7:0] y, input logic c, input int ndrv);
    if (reset) begin
      model_reset();
      return;
    end
    if (ldir)  m_ir  = memrd ? mem_rdata : y;
    if (ldmdr) m_mdr = memrd ? mem_rdata : y;
    if (ldmar) m_mar = y;
    if (ldsp)  m_sp  = y;
    if (ldpc)  m_pc  = y;
    if (ldt)   m_t   = y;
    if (M1 && fnsel <= 3'b101) begin m_z = (y == 0); m_n = y[7]; m_c = c; end
    if (ndrv > 1) m_berr = 1;
  endtask

  initial begin
    logic [7:0] v;
    int         drvmask[6];
    int         ctl, nd;
    logic [7:0] ey;
    logic       ec;

    reset = 1'b0;
    idle();

    tbl[0]  = '{"mar_pc",     TPC | LDMAR,                          3'b110, 1'b1, 8'h00, 8'h00, OBS_MAR,  8'h00};
    tbl[1]  = '{"fetch_ir",   TMAR | TPC | LDPC | LDIR | MEMRD,     3'b010, 1'b1, 8'hF8, 8'h00, OBS_IR,   8'h78};
    tbl[2]  = '{"fetch_pc",   0,                                    3'b110, 1'b0, 8'h00, 8'h00, TPC,      8'h01};
    tbl[3]  = '{"sp_dec",     TSP | LDSP,                           3'b011, 1'b1, 8'h00, 8'h00, TSP,      8'hFE};
    tbl[4]  = '{"t_from_rf",  RD | LDT,                             3'b110, 1'b0, 8'h00, 8'h3C, TT,       8'h3C};
    tbl[5]  = '{"pc_add",     TPC | LDPC,                           3'b000, 1'b1, 8'h00, 8'h00, TPC,      8'h3D};
    tbl[6]  = '{"mdr_rf",     RD | LDMDR,                           3'b110, 1'b0, 8'h00, 8'h33, OBS_MDR,  8'h33};
    tbl[7]  = '{"mar_or",     TMDR | LDMAR,                         3'b100, 1'b1, 8'h00, 8'h00, OBS_MAR,  8'h3F};
    tbl[8]  = '{"sp_not",     TMDR | LDSP,                          3'b101, 1'b1, 8'h00, 8'h00, TSP,     8'hCC};
    tbl[9]  = '{"t_neg",      TMDR | LDT,                           3'b001, 1'b1, 8'h00, 8'h00, TT,       8'hCD};
    tbl[10] = '{"m1_0_trans", TPC | LDPC,                           3'b000, 1'b0, 8'h00, 8'h00, TPC,      8'h3D};
    tbl[11] = '{"rsvd_trans", TSP | LDPC,                           3'b111, 1'b1, 8'h00, 8'h00, TPC,      8'hCC};
    tbl[12] = '{"mdr_mem",    MEMRD | LDMDR,                        3'b110, 1'b0, 8'hA5, 8'h00, OBS_MDR,  8'hA5};
    tbl[13] = '{"ir_from_y",  TMDR | LDIR,                          3'b110, 1'b0, 8'h00, 8'h00, OBS_IR,   8'h25};
    tbl[14] = '{"t_sext_ir",  TIR | LDT,                            3'b110, 1'b0, 8'h00, 8'h00, TT,       8'hFD};
    tbl[15] = '{"mdr_rdwr",   MEMRD | MEMWR | LDMDR,                3'b110, 1'b0, 8'h11, 8'h00, OBS_MDR,  8'h11};
    tbl[16] = '{"prio_mdr",   TMDR | TSP | LDMAR,                   3'b110, 1'b0, 8'h00, 8'h00, OBS_MAR,  8'h11};
    tbl[17] = '{"berr_stick", 0,                                    3'b110, 1'b0, 8'h00, 8'h00, OBS_BERR, 8'h01};

    // Reset state.
    do_reset();
    peek_check("rst_pc", TPC, 8'h00);
    peek_check("rst_sp", TSP, 8'hFF);
    peek_check("rst_t", TT, 8'h00);
    peek_check("rst_mar", OBS_MAR, 8'h00);
    peek_check("rst_mdr", OBS_MDR, 8'h00);
    peek_check("rst_ir", OBS_IR, 8'h00);
    peek_check("rst_berr", OBS_BERR, 8'h00);
    #1 check("rst_dcond", dcond, 1'b1);

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].ctl, tbl[i].fn, tbl[i].m1, tbl[i].mrd, tbl[i].rfd);
      peek_check(tbl[i].name, tbl[i].obs, tbl[i].exp);
    end

    // Reset clears flags; SP decrement flag behaviour including the borrow case.
    do_reset();
    check_flags("rst_flags", 1'b0, 1'b0, 1'b0);
    step(TSP | LDSP, 3'b011, 1'b1, 8'h00, 8'h00);
    peek_check("dec_ff", TSP, 8'hFE);
    check_flags("dec_ff_flags", 1'b0, 1'b1, 1'b1);
    step(RD | LDSP, 3'b110, 1'b0, 8'h00, 8'h00);
    step(TSP | LDSP, 3'b011, 1'b1, 8'h00, 8'h00);
    peek_check("dec_00", TSP, 8'hFF);
    check_flags("dec_00_flags", 1'b0, 1'b1, 1'b0);

    // Z=1, N=0, C=1 via inc of FF; then every branch code.
    step(RD, 3'b010, 1'b1, 8'h00, 8'hFF);
    for (int code = 0; code < 16; code++) begin
      set_code(4'(code));
      #1 check($sformatf("dcond_%0d", code), dcond, spec_cond(4'(code), 1'b1, 1'b0, 1'b1));
    end

    // Bus contention and its clearing by reset.
    do_reset();
    step(MEMRD | LDIR, 3'b110, 1'b0, 8'h0D, 8'h00);
    step(RD | LDPC, 3'b110, 1'b0, 8'h00, 8'h10);
    step(TIR | LDT, 3'b110, 1'b0, 8'h00, 8'h00);
    peek_check("t_fd", TT, 8'hFD);
    peek_check("berr_pre", OBS_BERR, 8'h00);
    step(TPC | TT | LDPC, 3'b000, 1'b1, 8'h00, 8'h00);
    peek_check("berr_set", OBS_BERR, 8'h01);
    do_reset();
    peek_check("berr_clr", OBS_BERR, 8'h00);
    step(RD | LDT, 3'b110, 1'b0, 8'h00, 8'hFD);
    step(RD | LDPC, 3'b110, 1'b0, 8'h00, 8'h10);
    step(TPC | LDPC, 3'b000, 1'b1, 8'h00, 8'h00);
    peek_check("pc_0d", TPC, 8'h0D);
    peek_check("berr_none", OBS_BERR, 8'h00);

    // Memory write strobes and simultaneous read/write.
    step(RD | LDMDR, 3'b110, 1'b0, 8'h00, 8'h5A);
    drive(MEMWR | WR | MEMRD | LDMDR, 3'b110, 1'b0, 8'h77, 8'h00);
    #1;
    check("mem_we", mem_we, 1'b1);
    check("rf_we", rf_we, 1'b1);
    check("mem_wdata", mem_wdata, 8'h5A);
    @(posedge clk); #1; idle();
    peek_check("mdr_rdwr_77", OBS_MDR, 8'h77);
    step(RD | LDMDR, 3'b110, 1'b0, 8'h00, 8'h33);
    peek_check("mdr_33", OBS_MDR, 8'h33);
    step(RD | LDMAR, 3'b110, 1'b0, 8'h00, 8'h9C);
    #1 check("addr_no_tmar", mem_addr, 8'h00);

    // Reset wins over a concurrent load.
    step(RD, 3'b010, 1'b1, 8'h00, 8'hFF);
    step(RD | LDPC, 3'b110, 1'b0, 8'h00, 8'h44);
    reset = 1'b1;
    drive(TPC | LDPC, 3'b010, 1'b1, 8'h00, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    peek_check("rst_over_pc", TPC, 8'h00);
    check_flags("rst_over_flags", 1'b0, 1'b0, 1'b0);

    // Randomized run against the reference model.
    drvmask = '{TIR, TMDR, TSP, TPC, TT, RD};
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      ctl = 0;
      nd = int'($urandom_range(0, 6));
      if (nd < 6) ctl |= drvmask[nd];
      if ($urandom_range(0, 9) == 0) ctl |= drvmask[$urandom_range(0, 5)];
      for (int b = 0; b < 6; b++) if ($urandom_range(0, 2) == 0) ctl |= (1 << b);
      if ($urandom_range(0, 1) == 1) ctl |= TMAR;
      if ($urandom_range(0, 1) == 1) ctl |= MEMRD;
      if ($urandom_range(0, 1) == 1) ctl |= MEMWR;
      if ($urandom_range(0, 1) == 1) ctl |= WR;
      reset = ($urandom_range(0, 49) == 0);
      drive(ctl, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            8'($urandom), 8'($urandom));
      #1;
      model_eval(ey, ec, nd);
      check($sformatf("rand_%0d", n),
            {rf_wdata, mem_addr, mem_wdata, ir, dcond, bus_err, mem_we, rf_we},
            {ey, (tmar ? m_mar : 8'h00), m_mdr, m_ir[6:0],
             spec_cond(m_ir[6:3], m_z, m_n, m_c), m_berr, memwr, wr});
      @(posedge clk);
      model_update(ey, ec, nd);
      #1;
    end
    reset = 1'b0;
    idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
